// File: rtl/ram_array_ctrl.sv
// ram_array_ctrl
//   Synchronous single-port RAM array with a self-initialisation sweep,
//   a registered read port and a req/dat_valid handshake.
//   After reset (or a clr pulse) word i is loaded with INIT_VAL + i, one
//   word per cycle; busy is high for the DEPTH cycles of the sweep and
//   requests arriving then are dropped.
//
//   Optional feature (macro RAM_PARITY_CHK_EN): each word keeps an extra
//   even-parity bit; reads report a stored/computed mismatch on parity_err.
//   Without the macro parity_err is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous pulse, restarts the init sweep
//   req        in   access request, sampled when busy=0
//   we         in   1=write, 0=read (qualified by req)
//   addr       in   word address
//   datin      in   write data
//   busy       out  high during the init sweep
//   datout     out  registered read data, holds between reads
//   dat_valid  out  one-cycle pulse, datout valid
//   parity_err out  read parity mismatch, pulses with dat_valid
module ram_array_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter logic [31:0] INIT_VAL = 32'h90
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datin,
    output logic              busy,
    output logic [DATA_W-1:0] datout,
    output logic              dat_valid,
    output logic              parity_err
);

    localparam int unsigned       DEPTH  = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] INIT_W = INIT_VAL[DATA_W-1:0];

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] datout_q, datout_d;
    logic              dat_valid_q, dat_valid_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port shared by the init sweep and user writes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef RAM_PARITY_CHK_EN
    logic [DEPTH-1:0]  par_mem;
    logic              parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        datout_d    = datout_q;
        dat_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = datin;
`ifdef RAM_PARITY_CHK_EN
        parity_err_d = 1'b0;
`endif
        if (clr) begin
            // clr wins over everything, including a same-cycle request.
            state_d = ST_INIT;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q;
                    mem_wdata = INIT_W + DATA_W'(cnt_q);
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        if (we) begin
                            mem_we = 1'b1;
                        end else begin
                            datout_d    = mem[addr];
                            dat_valid_d = 1'b1;
`ifdef RAM_PARITY_CHK_EN
                            parity_err_d = par_mem[addr] ^ (^mem[addr]);
`endif
                        end
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            datout_q    <= '0;
            dat_valid_q <= 1'b0;
`ifdef RAM_PARITY_CHK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            datout_q    <= datout_d;
            dat_valid_q <= dat_valid_d;
`ifdef RAM_PARITY_CHK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Storage is not reset; contents are defined once the sweep completes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef RAM_PARITY_CHK_EN
    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_mem[mem_waddr] <= ^mem_wdata;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy      = busy_q;
    assign datout    = datout_q;
    assign dat_valid = dat_valid_q;

endmodule

// File: tb/tb_ram_array_ctrl.sv
module tb_ram_array_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, req, we;
    logic [2:0] addr;
    logic [7:0] datin;
    logic       busy, dat_valid, parity_err;
    logic [7:0] datout;

    // Second instance with a seed that wraps past 8'hFF.
    logic       req2;
    logic [2:0] addr2;
    logic       busy2, dat_valid2, parity_err2;
    logic [7:0] datout2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t       q1[$];
    logic [7:0] q2[$];
    logic [7:0] mem_m [8];

    always #5 clk = ~clk;

    ram_array_ctrl #(.DATA_W(8), .ADDR_W(3), .INIT_VAL(32'h90)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .we(we),
        .addr(addr), .datin(datin), .busy(busy), .datout(datout),
        .dat_valid(dat_valid), .parity_err(parity_err)
    );

    ram_array_ctrl #(.DATA_W(8), .ADDR_W(3), .INIT_VAL(32'hFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .req(req2), .we(1'b0),
        .addr(addr2), .datin(8'h00), .busy(busy2), .datout(datout2),
        .dat_valid(dat_valid2), .parity_err(parity_err2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: pop an expectation whenever a read result is presented.
    always @(negedge clk) begin
        if (dat_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_dat_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("rd_data", 32'(datout), 32'(e.d));
                check("rd_parity", 32'(parity_err), 32'(e.p));
            end
        end
    end

    always @(negedge clk) begin
        if (dat_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("unexpected_dat_valid2", 32'd1, 32'd0);
            end else begin
                logic [7:0] e2;
                e2 = q2.pop_front();
                check("rd_data_wrap", 32'(datout2), 32'(e2));
            end
        end
    end

    function automatic void model_init();
        for (int i = 0; i < 8; i++) mem_m[i] = 8'(8'h90 + i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        req = 1'b1; we = 1'b1; addr = a; datin = d;
        mem_m[a] = d;
        tick();
        req = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic p);
        req = 1'b1; we = 1'b0; addr = a;
        q1.push_back('{mem_m[a], p});
        tick();
        req = 1'b0;
        check("rd_latency", 32'(dat_valid), 32'd1);
    endtask

    // Counts cycles until busy drops, throwing random requests that must be ignored.
    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            req   = 1'($urandom);
            we    = 1'($urandom);
            addr  = 3'($urandom);
            datin = 8'($urandom);
            tick();
            n++;
        end while (busy === 1'b1 && n < 50);
        req = 1'b0;
        check(nm, 32'(n), 32'd8);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; req = 1'b0; we = 1'b0; addr = '0; datin = '0;
        req2 = 1'b0; addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_datout", 32'(datout), 32'd0);
        check("rst_valid", 32'(dat_valid), 32'd0);
        check("rst_parity", 32'(parity_err), 32'd0);

        rst_n = 1'b1;
        wait_idle("busy_len_reset");
        model_init();

        // Init pattern, back-to-back reads.
        for (int i = 0; i < 8; i++) rd(3'(i), 1'b0);
        tick();

        // Wrapped seed on the second instance.
        check("busy2_idle", 32'(busy2), 32'd0);
        req2 = 1'b1; addr2 = 3'd3; q2.push_back(8'hFF); tick();
        addr2 = 3'd4; q2.push_back(8'h00); tick();
        addr2 = 3'd7; q2.push_back(8'h03); tick();
        req2 = 1'b0;
        tick();

        // Read-after-write.
        wr(3'd3, 8'hA5);
        rd(3'd3, 1'b0);
        rd(3'd4, 1'b0);
        tick();

        // clr with a simultaneous read: the read is dropped and the sweep reruns.
        wr(3'd2, 8'h11);
        clr = 1'b1; req = 1'b1; we = 1'b0; addr = 3'd2;
        tick();
        clr = 1'b0; req = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        wait_idle("busy_len_clr");
        model_init();
        rd(3'd2, 1'b0);
        tick();

        // Reset in the middle of a sweep.
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (4) tick();
        check("datout_hold_sweep", 32'(datout), 32'h92);
        rst_n = 1'b0;
        #1;
        check("midrst_datout", 32'(datout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_valid", 32'(dat_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_idle("busy_len_midrst");
        model_init();
        rd(3'd6, 1'b0);
        tick();

`ifdef RAM_PARITY_CHK_EN
        begin
            logic [7:0] pv;
            wr(3'd5, 8'h07);
            pv = dut.par_mem;
            force dut.par_mem = pv ^ 8'h20;
            rd(3'd5, 1'b1);
            tick();
            release dut.par_mem;
            wr(3'd5, 8'h07);
            rd(3'd5, 1'b0);
            tick();
        end
`endif

        // Randomised traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            logic [2:0]  a;
            op = $urandom_range(0, 3);
            a  = 3'($urandom);
            if (op == 0) tick();
            else if (op == 1) wr(a, 8'($urandom));
            else rd(a, 1'b0);
        end
        repeat (3) tick();

        check("scoreboard_drain", 32'(q1.size()), 32'd0);
        check("scoreboard_drain2", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
